bcd_serial_subtractor: RTL and testbench
========================================

// Module: bcd_serial_subtractor
// PURPOSE
//  Sequential packed-BCD subtractor: Diff = A - B - Borrow_in, one digit per clock, LSD first.
//  Inverse-direction companion to the team's combinational BCD adder: same operand widths and
//  packing, so adder/subtractor results cross-check digit for digit.
//  Sits behind a valid/ready handshake on both sides; one operation in flight at a time.
// PARAMETERS
//  DIGITS   2   number of BCD digits per operand; data width W = 4*DIGITS
// PORTS
//  clk        in   1    single clock, all logic on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    operands valid
//  in_ready   out  1    block idle, can accept operands
//  A          in   W    minuend, packed BCD, digit 0 in [3:0]
//  B          in   W    subtrahend, packed BCD
//  Borrow_in  in   1    borrow into digit 0
//  out_valid  out  1    result valid, held until accepted
//  out_ready  in   1    downstream accepts result
//  Diff       out  W    packed BCD difference (ten's-complement wrap when negative)
//  Borrow_out out  1    borrow out of MSD (1 => A < B + Borrow_in)
//  Err        out  1    any digit of A or B > 9 in the accepted operands
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1 (from the first cycle after rst deasserts),
//    out_valid=0, Diff=0, Borrow_out=0, Err=0, digit index=0.
//  - FSM: IDLE -> CALC on in_valid&in_ready; CALC -> DONE after digit DIGITS-1;
//    DONE -> IDLE on out_valid&out_ready.
//  - IDLE: in_ready=1. On accept: latch A, B, Borrow_in; compute Err from all input digits;
//    clear Diff; index=0.
//  - CALC: in_ready=0. Per cycle, digit i: r = a_i - b_i - br (signed, 6 bits).
//    If r<0: d_i = (r+10)[3:0], br=1; else d_i = r[3:0], br=0. Write d_i into Diff[4i+3:4i]; i++.
//  - Digits >9 are not corrected: same formula, 4-bit truncation; Err=1 flags the result
//    as meaningless.
//  - DONE: out_valid=1. Diff, Borrow_out (final br) and Err stable while out_valid=1 and
//    out_ready=0 (backpressure, unlimited).
//  - Latency: accept edge at cycle 0 -> out_valid high at cycle DIGITS+1.
//    Min accept-to-accept interval is DIGITS+2 cycles. in_ready is low in CALC and DONE
//    (no overlap with the DONE cycle).
//  - Handshake pass: on out_valid&out_ready, next cycle is IDLE with in_ready=1.
//    Diff/Borrow_out/Err keep their last values until the next accept; out_valid=0.
//  - in_valid while in_ready=0: ignored; not queued.
//  - out_ready while out_valid=0: no effect.
//  - rst mid-operation (CALC or DONE): abort, return to reset values next cycle;
//    no partial result appears.
//  - Borrow chain wraps: an all-zero A with B=0 and Borrow_in=1 gives all-nines,
//    Borrow_out=1.
//  - Result in ten's complement: Diff = (A - B - Borrow_in) mod 10^DIGITS.
// TESTING  (DIGITS=2)
//  - A=0x58 B=0x49 Bin=0 -> Diff=0x09 Bout=0 Err=0; out_valid exactly 3 cycles after accept
//  - A=0x49 B=0x58 Bin=0 -> Diff=0x91 Bout=1; A=0x05 B=0x05 Bin=1 -> Diff=0x99 Bout=1
//  - A=0x99 B=0x99 -> 0x00 Bout=0; A=0x00 B=0x00 Bin=0 -> 0x00 Bout=0;
//    each result + B + Bin through the BCD adder equals A
//  - A=0x1A B=0x03 -> Err=1, out_valid still after 3 cycles;
//    next op A=0x26 B=0x15 Bin=1 -> Diff=0x10 Err=0
//  - Backpressure: out_ready=0 for 5 cycles -> outputs stable, in_ready=0,
//    extra in_valid ignored; then accept -> in_ready=1 next cycle
//  - rst asserted in CALC after digit 0 -> next cycle in_ready=1, out_valid=0, Diff=0, Err=0;
//    following op completes normally

Source files
------------

// File: rtl/bcd_serial_subtractor.sv
// Packed-BCD subtractor, one digit per clock, LSD first.
// Valid/ready on both sides, one operation in flight.
module bcd_serial_subtractor #(
  parameter int DIGITS = 2,
  localparam int W = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Borrow_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Diff,
  output logic         Borrow_out,
  output logic         Err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           br;
  logic [IW-1:0]  idx;

  logic [3:0]     a_d;
  logic [3:0]     b_d;
  logic [5:0]     r;
  logic [3:0]     d_i;
  logic           br_nx;
  logic           in_err;

  always_comb begin
    a_d   = a_r[4*int'(idx) +: 4];
    b_d   = b_r[4*int'(idx) +: 4];
    r     = {2'b00, a_d} - {2'b00, b_d} - {5'b0, br};
    br_nx = r[5];
    // low nibble of r+10 equals r[3:0]+10 modulo 16
    d_i   = br_nx ? (r[3:0] + 4'd10) : r[3:0];
  end

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (A[4*i +: 4] > 4'd9) in_err = 1'b1;
      if (B[4*i +: 4] > 4'd9) in_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      Diff       <= '0;
      Borrow_out <= 1'b0;
      Err        <= 1'b0;
      idx        <= '0;
      a_r        <= '0;
      b_r        <= '0;
      br         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r        <= A;
            b_r        <= B;
            br         <= Borrow_in;
            Err        <= in_err;
            Diff       <= '0;
            Borrow_out <= 1'b0;
            idx        <= '0;
            in_ready   <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          Diff[4*int'(idx) +: 4] <= d_i;
          br <= br_nx;
          if (idx == IW'(DIGITS - 1)) begin
            Borrow_out <= br_nx;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGITS=2)
// with a queue scoreboard of expected results.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 2;
  localparam int W = 4 * DIGITS;
  localparam int MODV = 100;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Diff;
  logic         Borrow_out;
  logic         Err;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .Borrow_in  (Borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Diff       (Diff),
    .Borrow_out (Borrow_out),
    .Err        (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [W-1:0] v);
    int s;
    s = 0;
    for (int i = DIGITS - 1; i >= 0; i--) s = s * 10 + int'(v[4*i +: 4]);
    return s;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] v;
    int m;
    v = '0;
    m = n;
    for (int i = 0; i < DIGITS; i++) begin
      v[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expectation for valid BCD operands from plain decimal arithmetic.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic err,
                          input logic [W-1:0] d_err, input logic bo_err);
    exp_t e;
    int r;
    e.a = a;
    e.b = b;
    e.bin = bin;
    e.err = err;
    if (err) begin
      e.d = d_err;
      e.bo = bo_err;
    end else begin
      r = bcd2int(a) - bcd2int(b) - int'(bin);
      e.bo = (r < 0);
      e.d = int2bcd((r + MODV) % MODV);
    end
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic err,
                          input logic [W-1:0] d_err, input logic bo_err);
    int n;
    A = a;
    B = b;
    Borrow_in = bin;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_wait", 32'(in_ready), 32'd1);
    push_exp(a, b, bin, err, d_err, bo_err);
    tick();
    in_valid = 1'b0;
  endtask

  // Called one cycle after the accept edge; hold = extra stall cycles.
  task automatic get_result(input int hold);
    exp_t e;
    int cyc;
    logic [W-1:0] d0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(DIGITS + 1));
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("diff", 32'(Diff), 32'(e.d));
    chk("borrow_out", 32'(Borrow_out), 32'(e.bo));
    chk("err", 32'(Err), 32'(e.err));
    if (!e.err)
      chk("adder_xcheck",
          32'((bcd2int(Diff) + bcd2int(e.b) + int'(e.bin)) % MODV),
          32'(bcd2int(e.a)));
    d0 = Diff;
    for (int i = 0; i < hold; i++) begin
      A = W'($urandom);
      B = W'($urandom);
      in_valid = 1'b1;
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_diff", 32'(Diff), 32'(d0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_diff_kept", 32'(Diff), 32'(e.d));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    Borrow_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(Diff), 32'd0);
    chk("rst_bout", 32'(Borrow_out), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);

    // out_ready with nothing pending has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_ready", 32'(out_valid), 32'd0);

    start_op(8'h58, 8'h49, 1'b0, 1'b0, '0, 1'b0);
    get_result(0);
    start_op(8'h49, 8'h58, 1'b0, 1'b0, '0, 1'b0);
    get_result(0);
    start_op(8'h05, 8'h05, 1'b1, 1'b0, '0, 1'b0);
    get_result(0);
    start_op(8'h99, 8'h99, 1'b0, 1'b0, '0, 1'b0);
    get_result(0);
    start_op(8'h00, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    get_result(0);
    start_op(8'h00, 8'h00, 1'b1, 1'b0, '0, 1'b0);
    get_result(0);
    // 0x1A - 0x03: digit0 10-3=7, digit1 1-0=1
    start_op(8'h1A, 8'h03, 1'b0, 1'b1, 8'h17, 1'b0);
    get_result(0);
    start_op(8'h26, 8'h15, 1'b1, 1'b0, '0, 1'b0);
    get_result(0);

    start_op(8'h73, 8'h28, 1'b0, 1'b0, '0, 1'b0);
    get_result(5);
    // stray in_valid during stall must not have been queued
    tick();
    tick();
    tick();
    tick();
    chk("no_queued_op", 32'(out_valid), 32'd0);
    chk("no_queued_rdy", 32'(in_ready), 32'd1);

    // abort in CALC once digit 0 has been written
    start_op(8'h3A, 8'h11, 1'b0, 1'b1, 8'h29, 1'b0);
    void'(sb.pop_back());
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_diff", 32'(Diff), 32'd0);
    chk("abort_err", 32'(Err), 32'd0);
    start_op(8'h61, 8'h37, 1'b0, 1'b0, '0, 1'b0);
    get_result(0);

    for (int k = 0; k < 6; k++) begin
      start_op(int2bcd($urandom_range(99)), int2bcd($urandom_range(99)),
               1'($urandom_range(1)), 1'b0, '0, 1'b0);
      get_result(k % 2);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
